// File: rtl/unidad_multiciclo.sv
// Multicycle main control FSM for the MIPS datapath: sequences fetch, decode,
// execute, memory and write-back over a shared memory port and ALU.
module unidad_multiciclo #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       pcsrc,
  output logic [2:0] alop,
  output logic [3:0] state,
  output logic       illegal,
  output logic       memerr
);

  localparam int unsigned CW = 8;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    RTEX   = 4'd6,
    RTWB   = 4'd7,
    BEQEX  = 4'd8,
    IMMEX  = 4'd9,
    IMMWB  = 4'd10
  } state_t;

  state_t         st, nst;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           waiting, timeout;

  // Timeout counts stalled cycles in a memory state; mem_ready always wins.
  assign waiting = ((st == FETCH) || (st == MEMRD) || (st == MEMWR)) && !mem_ready;
  assign timeout = waiting && (cnt == CW'(WAIT_MAX - 1));
  assign cnt_nxt = (waiting && !timeout) ? cnt + CW'(1) : '0;
  assign state   = st;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st  <= nst;
      cnt <= cnt_nxt;
    end
  end

  always_comb begin
    nst      = st;
    pcen     = 1'b0;
    iord     = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memreg   = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 1'b0;
    alop     = 3'b000;
    illegal  = 1'b0;
    memerr   = 1'b0;
    case (st)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          nst     = DECODE;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          6'b100011, 6'b101011:                         nst = MEMADR;
          6'b000000:                                    nst = RTEX;
          6'b000100:                                    nst = BEQEX;
          6'b001000, 6'b001100, 6'b001010, 6'b001101:   nst = IMMEX;
          default: begin
            illegal = 1'b1;
            nst     = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        nst     = (op == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
        if (mem_ready) nst = MEMWB;
      end
      MEMWB: begin
        regwrite = 1'b1;
        memreg   = 1'b1;
        nst      = FETCH;
      end
      MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
        if (mem_ready) nst = FETCH;
      end
      RTEX: begin
        alusrca = 1'b1;
        alop    = 3'b111;
        nst     = RTWB;
      end
      RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        nst      = FETCH;
      end
      BEQEX: begin
        alusrca = 1'b1;
        alop    = 3'b001;
        pcsrc   = 1'b1;
        pcen    = zero;
        nst     = FETCH;
      end
      IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        case (op)
          6'b001100: alop = 3'b101;
          6'b001010: alop = 3'b010;
          6'b001101: alop = 3'b110;
          default:   alop = 3'b000;
        endcase
        nst = IMMWB;
      end
      IMMWB: begin
        regwrite = 1'b1;
        nst      = FETCH;
      end
      default: nst = FETCH;
    endcase
    // A timed-out access is dropped: no request, no PC/IR update.
    if (timeout) begin
      memerr   = 1'b1;
      memread  = 1'b0;
      memwrite = 1'b0;
      nst      = FETCH;
    end
    if (rst) begin
      {pcen, iord, memread, memwrite, irwrite, regdst, memreg, regwrite} = '0;
      {alusrca, alusrcb, pcsrc, alop, illegal, memerr} = '0;
    end
  end

endmodule

// File: tb/tb_unidad_multiciclo.sv
// Directed self-checking bench for the multicycle MIPS control FSM.
module tb_unidad_multiciclo;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pcen, iord, memread, memwrite, irwrite, regdst, memreg, regwrite;
  logic       alusrca, pcsrc, illegal, memerr;
  logic [1:0] alusrcb;
  logic [2:0] alop;
  logic [3:0] state;
  int         errors = 0;
  int         checks = 0;

  unidad_multiciclo #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memreg(memreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alop(alop),
    .state(state), .illegal(illegal), .memerr(memerr)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] allout;
    rst = 1'b1; op = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    nxt();
    allout = {pcen, iord, memread, memwrite, irwrite, regdst, memreg, regwrite,
              alusrca, alusrcb, pcsrc, alop, state, illegal, memerr};
    checks++;
    if (allout !== 21'd0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", allout); end
    rst = 1'b0;
    #1;
    checks++;
    if ({state, memread, pcen, irwrite, alusrcb} !== {4'd0, 1'b1, 1'b1, 1'b1, 2'b01}) begin
      errors++; $display("FAIL fetch_after_reset: got %b exp 0000111_01",
                         {state, memread, pcen, irwrite, alusrcb});
    end
  endtask

  task automatic test_rtype();
    op = 6'b000000; mem_ready = 1'b1;
    nxt();
    checks++;
    if ({state, alusrcb, regwrite} !== {4'd1, 2'b11, 1'b0}) begin
      errors++; $display("FAIL rtype_decode: got %b", {state, alusrcb, regwrite});
    end
    nxt();
    checks++;
    if ({state, alusrca, alusrcb, alop, regwrite} !== {4'd6, 1'b1, 2'b00, 3'b111, 1'b0}) begin
      errors++; $display("FAIL rtype_ex: got %b", {state, alusrca, alusrcb, alop, regwrite});
    end
    nxt();
    checks++;
    if ({state, regwrite, regdst, memreg} !== {4'd7, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rtype_wb: got %b", {state, regwrite, regdst, memreg});
    end
    nxt();
    checks++;
    if ({state, regwrite, pcen, irwrite} !== {4'd0, 1'b0, 1'b1, 1'b1}) begin
      errors++; $display("FAIL rtype_return: got %b", {state, regwrite, pcen, irwrite});
    end
  endtask

  task automatic test_lw_stall();
    op = 6'b100011; mem_ready = 1'b1;
    nxt();
    nxt();
    checks++;
    if ({state, alusrca, alusrcb} !== {4'd2, 1'b1, 2'b10}) begin
      errors++; $display("FAIL lw_memadr: got %b", {state, alusrca, alusrcb});
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      checks++;
      if ({state, memread, iord, memerr} !== {4'd3, 1'b1, 1'b1, 1'b0}) begin
        errors++; $display("FAIL lw_stall%0d: got %b", i, {state, memread, iord, memerr});
      end
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd3) begin errors++; $display("FAIL lw_ready_cycle: got %0d exp 3", state); end
    nxt();
    checks++;
    if ({state, regwrite, memreg, regdst} !== {4'd4, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL lw_wb: got %b", {state, regwrite, memreg, regdst});
    end
    nxt();
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL lw_return: got %0d exp 0", state); end
  endtask

  task automatic test_beq();
    logic [1:0] zv;
    zv = 2'b10;
    op = 6'b000100; mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      zero = zv[1-k];
      nxt();
      nxt();
      checks++;
      if ({state, pcen, pcsrc, alop, alusrca} !== {4'd8, zv[1-k], 1'b1, 3'b001, 1'b1}) begin
        errors++; $display("FAIL beq_zero%0d: got %b", zv[1-k], {state, pcen, pcsrc, alop, alusrca});
      end
      nxt();
      checks++;
      if (state !== 4'd0) begin errors++; $display("FAIL beq_return%0d: got %0d exp 0", k, state); end
    end
    zero = 1'b0;
  endtask

  task automatic test_imm();
    logic [5:0] ops [4];
    logic [2:0] exp [4];
    ops = '{6'b001101, 6'b001010, 6'b001100, 6'b001000};
    exp = '{3'b110, 3'b010, 3'b101, 3'b000};
    mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      op = ops[k];
      nxt();
      nxt();
      checks++;
      if ({state, alop, alusrca, alusrcb} !== {4'd9, exp[k], 1'b1, 2'b10}) begin
        errors++; $display("FAIL imm_ex op=%b: got %b", ops[k], {state, alop, alusrca, alusrcb});
      end
      nxt();
      checks++;
      if ({state, regwrite, regdst, memreg} !== {4'd10, 1'b1, 1'b0, 1'b0}) begin
        errors++; $display("FAIL imm_wb op=%b: got %b", ops[k], {state, regwrite, regdst, memreg});
      end
      nxt();
    end
  endtask

  task automatic test_illegal();
    op = 6'b111111; mem_ready = 1'b1;
    nxt();
    checks++;
    if ({state, illegal, regwrite, memwrite} !== {4'd1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL illegal_pulse: got %b", {state, illegal, regwrite, memwrite});
    end
    nxt();
    checks++;
    if ({state, illegal, regwrite, memwrite} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL illegal_return: got %b", {state, illegal, regwrite, memwrite});
    end
  endtask

  task automatic test_sw_timeout(input logic late_ready);
    op = 6'b101011; mem_ready = 1'b1;
    nxt();
    nxt();
    mem_ready = 1'b0;
    nxt();
    for (int i = 1; i <= 15; i++) begin
      if (i > 1) nxt();
      if (i == 15 && late_ready) mem_ready = 1'b1;
      #1;
      checks++;
      if ({state, memerr, memwrite} !== {4'd5, (i == 15) && !late_ready, (i != 15) || late_ready}) begin
        errors++; $display("FAIL sw_wait late=%0d cyc%0d: got %b", late_ready, i, {state, memerr, memwrite});
      end
    end
    nxt();
    checks++;
    if ({state, memerr, memwrite} !== {4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL sw_after late=%0d: got %b", late_ready, {state, memerr, memwrite});
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_fetch_timeout();
    mem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      if (i > 1) nxt();
      #1;
      checks++;
      if ({state, memerr, pcen, irwrite} !== {4'd0, i == 15, 1'b0, 1'b0}) begin
        errors++; $display("FAIL fetch_wait cyc%0d: got %b", i, {state, memerr, pcen, irwrite});
      end
    end
    nxt();
    checks++;
    if ({state, memerr} !== {4'd0, 1'b0}) begin
      errors++; $display("FAIL fetch_retry: got %b exp 00000", {state, memerr});
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({pcen, irwrite} !== 2'b11) begin
      errors++; $display("FAIL fetch_resume: got %b exp 11", {pcen, irwrite});
    end
  endtask

  task automatic test_reset_mid();
    op = 6'b000000; mem_ready = 1'b1;
    nxt();
    nxt();
    nxt();
    rst = 1'b1;
    #1;
    checks++;
    if ({state, regwrite, regdst} !== {4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_mid: got %b", {state, regwrite, regdst});
    end
    nxt();
    rst = 1'b0;
    #1;
    checks++;
    if ({state, regwrite, irwrite} !== {4'd0, 1'b0, 1'b1}) begin
      errors++; $display("FAIL reset_mid_release: got %b", {state, regwrite, irwrite});
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stall();
    test_beq();
    test_imm();
    test_illegal();
    test_sw_timeout(1'b0);
    test_sw_timeout(1'b1);
    test_fetch_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidad_multiciclo.md
Name: unidad_multiciclo

Overview:
- Multicycle main control FSM for the MIPS datapath; replaces single-cycle opcode decode with a per-instruction state sequence.
- Shares one memory port and one ALU between fetch, address calculation, execute and PC increment.
- Sits between the instruction register opcode field, the ALU zero flag and the memory ready line; drives all datapath muxes and enables.
- Same opcode set and ALU op encoding as the existing single-cycle decoder.

Parameters:
- WAIT_MAX, 15: maximum consecutive cycles a memory state waits for mem_ready before abort; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- op  in  6  opcode from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pcen  out  1  PC write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memread  out  1  memory read request.
- memwrite  out  1  memory write request.
- irwrite  out  1  instruction register load.
- regdst  out  1  destination register select: 1 = rd, 0 = rt.
- memreg  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- regwrite  out  1  register file write enable.
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
- pcsrc  out  1  PC source: 0 = ALU result, 1 = ALUOut (branch target).
- alop  out  3  ALU op: 000 add, 001 sub, 010 slt, 101 and, 110 or, 111 R-type funct decode.
- state  out  4  current state code, for debug.
- illegal  out  1  one-cycle pulse on an unsupported opcode.
- memerr  out  1  one-cycle pulse on memory timeout.

Behaviour:
- Reset: rst high forces state to FETCH (0) and clears the wait counter. While rst is high, every output is 0.
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, IMMEX 9, IMMWB 10. Codes 11-15 go to FETCH on the next clock.
- Default value of every output in every state is 0. Only the signals listed below are asserted.
- FETCH:
  - Asserts memread, iord=0, alusrca=0, alusrcb=01, alop=000, pcsrc=0.
  - irwrite and pcen are asserted only when mem_ready=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - alusrca=0, alusrcb=11, alop=000 (branch target into ALUOut).
  - Next state by op: 100011 or 101011 -> MEMADR; 000000 -> RTEX; 000100 -> BEQEX; 001000, 001100, 001010, 001101 -> IMMEX.
  - Any other op: pulse illegal and go to FETCH.
- MEMADR: alusrca=1, alusrcb=10, alop=000. Next MEMRD if op=100011, else MEMWR.
- MEMRD: memread, iord=1. On mem_ready go to MEMWB.
- MEMWB: regwrite, memreg=1, regdst=0, then FETCH.
- MEMWR: memwrite, iord=1. On mem_ready go to FETCH.
- RTEX: alusrca=1, alusrcb=00, alop=111, then RTWB.
- RTWB: regwrite, regdst=1, memreg=0, then FETCH.
- BEQEX: alusrca=1, alusrcb=00, alop=001, pcsrc=1. pcen=zero (same-cycle, combinational). Then FETCH.
- IMMEX: alusrca=1, alusrcb=10. alop is 000 for addi, 101 for andi, 010 for slti, 110 for ori. Then IMMWB.
- IMMWB: regwrite, regdst=0, memreg=0, then FETCH.
- Cycle counts with mem_ready tied to 1: lw 5, sw 4, R-type 4, beq 3, immediate ops 4.
- Wait counter (memory timeout):
  - Counts consecutive cycles in FETCH, MEMRD or MEMWR with mem_ready=0; clears on any state change.
  - When the count reaches WAIT_MAX, pulse memerr and go to FETCH. No write is issued, and pcen and irwrite stay 0 that cycle.
  - A timeout in FETCH retries the same PC.
- mem_ready arriving in the same cycle the count reaches WAIT_MAX: mem_ready wins; no memerr.
- The op input is sampled only in DECODE, MEMADR and IMMEX. The instruction register holds op stable for the rest of the instruction.
- Asserting rst mid-instruction aborts it immediately; no partial write-back occurs after rst.

Test Plan:
- Reset, then release with mem_ready=1 and op=000000 -> states 0,1,6,7,0. regwrite=1 and regdst=1 only in state 7. pcen=1 and irwrite=1 in state 0.
- lw (op=100011) with mem_ready low for 3 cycles in MEMRD -> state 3 held 4 cycles, then state 4 with regwrite=1, memreg=1. Total 8 cycles.
- beq (op=000100) run twice: zero=1 -> pcen=1, pcsrc=1 in state 8; zero=0 -> pcen=0. Both return to state 0.
- Immediate ops: ori (op=001101) -> alop=110 in state 9; slti (op=001010) -> alop=010; andi (op=001100) -> alop=101. Each followed by IMMWB with regwrite=1, regdst=0.
- op=111111 in DECODE -> illegal pulses for 1 cycle, next state 0, no regwrite or memwrite ever asserted.
- sw (op=101011) with mem_ready=0 for 15 cycles and WAIT_MAX=15 -> memerr pulse, state 0, memwrite deasserted. Repeat with mem_ready=1 on cycle 15 -> no memerr, normal completion.
